// File: rtl/score_text_draw.sv
// Score text overlay: scans the raster, asks the code provider for the character under the
// beam, fetches its glyph row from the font ROM and paints set pixels over the RGB stream.
// Three-stage pipeline; every timing signal is delayed to stay aligned with the drawn pixel.
module score_text_draw #(
  parameter int unsigned XPOS       = 16,
  parameter int unsigned YPOS       = 8,
  parameter int unsigned COLS       = 2,
  parameter int unsigned ROWS       = 1,
  parameter logic [11:0] TEXT_COLOR = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [7:0]  char_yx,
  input  logic [7:0]  char_code,
  output logic [3:0]  char_line,
  output logic [10:0] char_addr,
  input  logic [7:0]  char_pixels,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  localparam logic [10:0] XLo = 11'(XPOS);
  localparam logic [10:0] XHi = 11'(XPOS + 8 * COLS);
  localparam logic [10:0] YLo = 11'(YPOS);
  localparam logic [10:0] YHi = 11'(YPOS + 16 * ROWS);

  logic [10:0] rel_x, rel_y;
  logic        in_box;

  // T1 registers
  logic [3:0]  line_d1;
  logic [2:0]  xbit_d1;
  logic        in_box_d1;
  logic [10:0] hcount_d1, vcount_d1;
  logic        hsync_d1, vsync_d1, hblnk_d1, vblnk_d1;
  logic [11:0] rgb_d1;

  // T2 registers
  logic [2:0]  xbit_d2;
  logic        in_box_d2;
  logic [10:0] hcount_d2, vcount_d2;
  logic        hsync_d2, vsync_d2, hblnk_d2, vblnk_d2;
  logic [11:0] rgb_d2;

  logic [2:0]  pix_idx;
  logic        pix;
  logic        unused_bits;

  // T0: box hit test on absolute counters and character request to the provider
  always_comb begin
    rel_x   = hcount_in - XLo;
    rel_y   = vcount_in - YLo;
    in_box  = (hcount_in >= XLo) && (hcount_in < XHi) &&
              (vcount_in >= YLo) && (vcount_in < YHi);
    char_yx = in_box ? {rel_y[7:4], rel_x[6:3]} : 8'hFF;
  end

  // Font ROM address; the provider's char_code is already aligned with T1
  always_comb begin
    char_line = line_d1;
    char_addr = {char_code[6:0], line_d1};
  end

  assign unused_bits = ^{rel_x[10:7], rel_y[10:8], char_code[7]};

  // T1: latch glyph coordinates and first delay of timing/colour
  always_ff @(posedge clk) begin
    if (rst) begin
      line_d1   <= '0;
      xbit_d1   <= '0;
      in_box_d1 <= 1'b0;
      hcount_d1 <= '0;
      vcount_d1 <= '0;
      hsync_d1  <= 1'b0;
      vsync_d1  <= 1'b0;
      hblnk_d1  <= 1'b0;
      vblnk_d1  <= 1'b0;
      rgb_d1    <= '0;
    end else begin
      line_d1   <= rel_y[3:0];
      xbit_d1   <= rel_x[2:0];
      in_box_d1 <= in_box;
      hcount_d1 <= hcount_in;
      vcount_d1 <= vcount_in;
      hsync_d1  <= hsync_in;
      vsync_d1  <= vsync_in;
      hblnk_d1  <= hblnk_in;
      vblnk_d1  <= vblnk_in;
      rgb_d1    <= rgb_in;
    end
  end

  // T2: second delay while the font ROM produces the glyph row
  always_ff @(posedge clk) begin
    if (rst) begin
      xbit_d2   <= '0;
      in_box_d2 <= 1'b0;
      hcount_d2 <= '0;
      vcount_d2 <= '0;
      hsync_d2  <= 1'b0;
      vsync_d2  <= 1'b0;
      hblnk_d2  <= 1'b0;
      vblnk_d2  <= 1'b0;
      rgb_d2    <= '0;
    end else begin
      xbit_d2   <= xbit_d1;
      in_box_d2 <= in_box_d1;
      hcount_d2 <= hcount_d1;
      vcount_d2 <= vcount_d1;
      hsync_d2  <= hsync_d1;
      vsync_d2  <= vsync_d1;
      hblnk_d2  <= hblnk_d1;
      vblnk_d2  <= vblnk_d1;
      rgb_d2    <= rgb_d1;
    end
  end

  // Select the glyph bit under the beam; bit 7 is the leftmost pixel
  always_comb begin
    pix_idx = 3'd7 - xbit_d2;
    pix     = char_pixels[pix_idx];
  end

  // T3: composite text over background, black during blanking
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= hcount_d2;
      vcount_out <= vcount_d2;
      hsync_out  <= hsync_d2;
      vsync_out  <= vsync_d2;
      hblnk_out  <= hblnk_d2;
      vblnk_out  <= vblnk_d2;
      if (hblnk_d2 || vblnk_d2) begin
        rgb_out <= 12'h000;
      end else if (in_box_d2 && pix) begin
        rgb_out <= TEXT_COLOR;
      end else begin
        rgb_out <= rgb_d2;
      end
    end
  end

endmodule

// File: tb/tb_score_text_draw.sv
// Randomized bench for score_text_draw with a provider/font environment and a queue of
// expected pixels computed from box geometry and glyph lookup.
module tb_score_text_draw;

  localparam int XPOS = 16;
  localparam int YPOS = 8;
  localparam int COLS = 2;
  localparam int ROWS = 1;
  localparam logic [11:0] TEXT = 12'hFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic [7:0]  char_yx;
  logic [7:0]  char_code;
  logic [3:0]  char_line;
  logic [10:0] char_addr;
  logic [7:0]  char_pixels;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  int n_checks = 0;
  int n_errors = 0;

  // Environment state
  int         score     = 7;
  int         font_mode = 0;
  logic [7:0] font_const = 8'h80;
  logic       hi_bit    = 1'b0;

  typedef struct {
    bit          valid;
    bit          zero;
    logic [11:0] rgb;
    logic [25:0] tim;
    logic [10:0] addr;
    logic [7:0]  yx;
  } exp_t;

  exp_t exp_q[$];

  score_text_draw #(
    .XPOS(XPOS), .YPOS(YPOS), .COLS(COLS), .ROWS(ROWS), .TEXT_COLOR(TEXT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hcount_in  (hcount_in),
    .vcount_in  (vcount_in),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .hblnk_in   (hblnk_in),
    .vblnk_in   (vblnk_in),
    .rgb_in     (rgb_in),
    .char_yx    (char_yx),
    .char_code  (char_code),
    .char_line  (char_line),
    .char_addr  (char_addr),
    .char_pixels(char_pixels),
    .hcount_out (hcount_out),
    .vcount_out (vcount_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .hblnk_out  (hblnk_out),
    .vblnk_out  (vblnk_out),
    .rgb_out    (rgb_out)
  );

  always #5 clk = ~clk;

  // ASCII code shown at text cell (row, col): two-digit score, blanks elsewhere
  function automatic logic [6:0] glyph_code(input int row, input int col);
    if (row == 0 && col == 0) return 7'(8'h30 + score / 10);
    if (row == 0 && col == 1) return 7'(8'h30 + score % 10);
    return 7'h20;
  endfunction

  function automatic logic [7:0] font_row(input logic [6:0] code, input logic [3:0] line);
    int v;
    if (font_mode == 0) return font_const;
    v = (int'(code) * 29) ^ (int'(line) * 113) ^ 'h5A;
    return v[7:0];
  endfunction

  // Provider and font ROM are both registered, one cycle each
  always @(posedge clk) begin
    char_code   <= {hi_bit, glyph_code(int'(char_yx[7:4]), int'(char_yx[3:0]))};
    char_pixels <= font_row(char_addr[10:4], char_addr[3:0]);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Build the expected result for one input pixel
  function automatic exp_t model(input logic r, input logic [10:0] hc, input logic [10:0] vc,
                                 input logic hs, input logic vs, input logic hb,
                                 input logic vb, input logic [11:0] rgb);
    exp_t e;
    int   x, y;
    bit   hit;
    logic [6:0]  code;
    logic [7:0]  bits;
    logic [10:0] ry;
    x   = int'(hc) - XPOS;
    y   = int'(vc) - YPOS;
    hit = (x >= 0) && (x < 8 * COLS) && (y >= 0) && (y < 16 * ROWS);
    ry  = vc - 11'(YPOS);
    code = hit ? glyph_code(y / 16, x / 8) : 7'h20;
    e.valid = 1'b1;
    e.zero  = r;
    e.tim   = {hc, vc, hs, vs, hb, vb};
    e.addr  = {code, ry[3:0]};
    e.yx    = hit ? {4'(y / 16), 4'(x / 8)} : 8'hFF;
    bits    = font_row(code, ry[3:0]);
    if (hb || vb)                   e.rgb = 12'h000;
    else if (hit && bits[7 - x % 8]) e.rgb = TEXT;
    else                             e.rgb = rgb;
    return e;
  endfunction

  task automatic step(input logic r, input logic [10:0] hc, input logic [10:0] vc,
                      input logic hs, input logic vs, input logic hb, input logic vb,
                      input logic [11:0] rgb);
    exp_t e;
    exp_t t;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0 && exp_q[$].valid && !exp_q[$].zero) begin
      check_eq("char_addr", 32'(char_addr), 32'(exp_q[$].addr));
      check_eq("char_line", 32'(char_line), 32'(exp_q[$].addr[3:0]));
    end
    if (exp_q.size() == 3) begin
      e = exp_q.pop_front();
      if (e.valid) begin
        check_eq("rgb_out", 32'(rgb_out), e.zero ? 32'h0 : 32'(e.rgb));
        check_eq("timing_out",
                 32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}),
                 e.zero ? 32'h0 : 32'(e.tim));
      end
    end
    rst = r; hcount_in = hc; vcount_in = vc;
    hsync_in = hs; vsync_in = vs; hblnk_in = hb; vblnk_in = vb; rgb_in = rgb;
    // A reset edge within the next three cycles wipes any pixel still in flight
    if (r) begin
      for (int i = 0; i < exp_q.size(); i++) begin
        t = exp_q[i]; t.zero = 1'b1; exp_q[i] = t;
      end
    end
    e = model(r, hc, vc, hs, vs, hb, vb, rgb);
    exp_q.push_back(e);
    #1;
    check_eq("char_yx", 32'(char_yx), 32'(e.yx));
  endtask

  // Environment changes make in-flight expectations ambiguous, so drop them
  task automatic set_env(input int s, input int mode, input logic [7:0] fc, input logic hb);
    exp_t t;
    for (int i = 0; i < exp_q.size(); i++) begin
      t = exp_q[i]; t.valid = 1'b0; exp_q[i] = t;
    end
    score = s; font_mode = mode; font_const = fc; hi_bit = hb;
  endtask

  task automatic px(input logic [10:0] hc, input logic [10:0] vc, input logic [11:0] rgb);
    step(1'b0, hc, vc, 1'b0, 1'b0, 1'b0, 1'b0, rgb);
  endtask

  task automatic flush();
    for (int i = 0; i < 3; i++) px(11'd0, 11'd0, 12'h000);
  endtask

  initial begin
    set_env(7, 0, 8'h80, 1'b0);
    // Reset with busy inputs
    step(1'b1, 11'd321, 11'd77, 1'b1, 1'b1, 1'b0, 1'b0, 12'hABC);
    step(1'b1, 11'd16, 11'd8, 1'b1, 1'b0, 1'b0, 1'b0, 12'h123);
    px(11'd50, 11'd60, 12'h456);
    check_eq("reset_rgb", 32'(rgb_out), 32'h0);
    check_eq("reset_hcount", 32'(hcount_out), 32'h0);
    px(11'd51, 11'd60, 12'h457);
    px(11'd52, 11'd60, 12'h458);

    // Pass-through and digit draw
    px(11'd100, 11'd100, 12'h0A5);
    check_eq("yx_outside", 32'(char_yx), 32'hFF);
    px(11'd16, 11'd8, 12'h321);
    check_eq("yx_char0", 32'(char_yx), 32'h00);
    px(11'd17, 11'd8, 12'h321);
    px(11'd24, 11'd8, 12'h321);
    check_eq("yx_char1", 32'(char_yx), 32'h01);
    flush();

    // Last glyph line, pixel from bit 3
    set_env(7, 0, 8'h08, 1'b0);
    px(11'd20, 11'd23, 12'h111);
    px(11'd21, 11'd23, 12'h111);
    flush();

    // Box edges
    set_env(7, 0, 8'h01, 1'b0);
    px(11'd15, 11'd8, 12'h222);
    px(11'd32, 11'd8, 12'h333);
    px(11'd16, 11'd24, 12'h444);
    px(11'd31, 11'd8, 12'h555);
    px(11'd23, 11'd8, 12'h666);
    // Blanking inside the box
    set_env(7, 0, 8'hFF, 1'b1);
    step(1'b0, 11'd16, 11'd8, 1'b0, 1'b0, 1'b1, 1'b0, 12'h777);
    step(1'b0, 11'd17, 11'd9, 1'b0, 1'b0, 1'b0, 1'b1, 12'h777);
    px(11'd18, 11'd9, 12'h777);
    flush();

    // Mid-frame reset
    px(11'd20, 11'd10, 12'h888);
    step(1'b1, 11'd21, 11'd10, 1'b1, 1'b1, 1'b1, 1'b1, 12'h999);
    step(1'b1, 11'd22, 11'd10, 1'b0, 1'b1, 1'b0, 1'b0, 12'h999);
    flush();

    // Randomized raster around the box
    for (int i = 0; i < 3000; i++) begin
      logic [10:0] hc, vc;
      if (i % 256 == 0) begin
        set_env(int'($urandom_range(0, 99)), int'($urandom_range(0, 1)),
                8'($urandom), 1'($urandom));
      end
      hc = ($urandom_range(0, 3) == 0) ? 11'($urandom) : 11'($urandom_range(8, 40));
      vc = ($urandom_range(0, 3) == 0) ? 11'($urandom) : 11'($urandom_range(0, 30));
      step(1'b0, hc, vc, 1'($urandom), 1'($urandom),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0), 12'($urandom));
    end
    flush();
    flush();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/score_text_draw.md
Name: score_text_draw

Overview:
- Consumer end of the score character interface: scans the VGA raster and issues `char_yx` requests to the score character-code provider.
- Takes the registered `char_code` it returns, fetches the glyph row from the 8x16 font ROM, and overlays the text pixels onto the incoming RGB stream.
- Sits in the VGA pipeline after the game-field/snake drawing stage and before the sync output registers.
- Delays all timing signals so they stay aligned with the drawn pixels.

Parameters:
- XPOS, 16, left edge of text box in pixels (hcount units)
- YPOS, 8, top edge of text box in pixels (vcount units)
- COLS, 2, text box width in characters (1..16)
- ROWS, 1, text box height in characters (1..16)
- TEXT_COLOR, 12'hFFF, RGB444 colour of set glyph pixels

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- hcount_in  in  11  horizontal pixel counter
- vcount_in  in  11  vertical line counter
- hsync_in  in  1  horizontal sync
- vsync_in  in  1  vertical sync
- hblnk_in  in  1  horizontal blanking
- vblnk_in  in  1  vertical blanking
- rgb_in  in  12  background pixel colour
- char_yx  out  8  character request {row[3:0], col[3:0]} to code provider
- char_code  in  8  ASCII code from provider; valid 1 cycle after char_yx
- char_line  out  4  glyph row index to font ROM
- char_addr  out  11  font ROM address = {char_code[6:0], char_line}
- char_pixels  in  8  font ROM row data; valid 1 cycle after char_addr; bit7 = leftmost pixel
- hcount_out, vcount_out  out  11 each  delayed counters
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each  delayed timing
- rgb_out  out  12  composited pixel

Behaviour:
- Clock `clk`; reset `rst` is synchronous, active-high. All registered outputs are 0 while `rst` is sampled high.
- Stage T0 (combinational from inputs):
  - rel_x = hcount_in - XPOS, rel_y = vcount_in - YPOS, both 11-bit.
  - in_box = (hcount_in >= XPOS) && (hcount_in < XPOS+8*COLS) && (vcount_in >= YPOS) && (vcount_in < YPOS+16*ROWS). Comparisons are done on absolute counters, so there is no wrap-around false hit.
  - char_yx = {rel_y[7:4], rel_x[6:3]} when in_box, else 8'hFF.
- Stage T1 (registered):
  - Latch rel_y[3:0], rel_x[2:0], in_box, all timing inputs and rgb_in.
  - char_line = latched rel_y[3:0].
  - char_addr is combinational from the provider's registered char_code and char_line; bit 7 of char_code is ignored.
- Stage T2 (registered): second delay of rel_x[2:0], in_box, timing and rgb. The font ROM delivers char_pixels here.
- Stage T3 (registered outputs):
  - pix = char_pixels[7 - rel_x_d2[2:0]].
  - If hblnk_d2 or vblnk_d2: rgb_out = 12'h000.
  - Else if in_box_d2 && pix: rgb_out = TEXT_COLOR.
  - Else: rgb_out = rgb_d2 (transparent background).
  - hcount_out, vcount_out, syncs and blanks = T2 copies.
- Fixed latency: 3 clk from any input to the matching output, including outside the box.
- The box is drawn independent of blanking. A box placed in the blanking region produces black output.
- Right/bottom edge: the pixel at hcount = XPOS+8*COLS is outside. The last glyph column drawn is bit0 of the last character.
- Reset mid-frame:
  - All pipeline registers clear on the reset cycle.
  - For 3 cycles after release, outputs carry zeros/pipeline fill, then track inputs.
  - No state persists across frames.
- A char_code change from the provider mid-character (score update) takes effect on the next pixel fetched. There is no frame-level latching.

Test Plan:
- Reset: hold rst 2 cycles with nonzero inputs -> all outputs 0; 3 cycles after release hcount_out equals hcount_in from 3 cycles earlier.
- Pass-through: hcount=100, vcount=100, rgb_in=12'h0A5, no blank -> rgb_out=12'h0A5 exactly 3 cycles later; char_yx=8'hFF.
- Digit draw: provider model with score=7, font model returning 8'h80 for every row -> at vcount=8: hcount=16 gives char_yx=8'h00, char_addr={7'h30,4'h0}, rgb_out=12'hFFF; hcount=17 gives background; hcount=24 gives char_yx=8'h01, char_addr={7'h37,4'h0}.
- Row index: vcount=23 (rel_y=15), hcount=20 -> char_line=4'hF; pixel taken from char_pixels bit3.
- Edges: hcount=15, hcount=32 and vcount=24 -> outside box, rgb passthrough; hcount=31 with font 8'h01 -> TEXT_COLOR.
- Blanking inside box: hblnk_in=1 at hcount=16, vcount=8 -> rgb_out=12'h000 and hblnk_out=1 after 3 cycles.
